// File: rtl/key_debounce.sv
// Two-flop synchroniser plus per-bit stability counter for active-low key lines.
// Optional KEY_DEBOUNCE_CHG_EN adds a one-cycle key_chg pulse on any key_out update.
module key_debounce #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DB_CYCLES = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_out
`ifdef KEY_DEBOUNCE_CHG_EN
    ,
    output logic             key_chg
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_key_out;
    logic [CNT_W-1:0] r_cnt     [WIDTH];
    logic [WIDTH-1:0] w_key_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];

    // Per-bit acceptance: a mismatch must persist for DB_CYCLES unbroken edges.
    always_comb begin
        w_key_nxt = r_key_out;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_cnt_nxt[i] = '0;
            if (r_s2[i] != r_key_out[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_key_nxt[i] = r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '1;
            r_s2      <= '1;
            r_key_out <= '1;
            r_cnt     <= '{default: '0};
        end else begin
            r_s1      <= key_raw;
            r_s2      <= r_s1;
            r_key_out <= w_key_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign key_out = r_key_out;

`ifdef KEY_DEBOUNCE_CHG_EN
    logic r_key_chg;

    // Pulse coincides with the key_out update so downstream sees both on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_chg <= 1'b0;
        end else begin
            r_key_chg <= (w_key_nxt != r_key_out);
        end
    end

    assign key_chg = r_key_chg;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce (DB_CYCLES=4): directed plan steps plus random key activity,
// checked against a sliding-window model of the acceptance rule.
module tb_key_debounce;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_raw;
    logic [7:0] key_out;
`ifdef KEY_DEBOUNCE_CHG_EN
    logic       key_chg;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Model state: raw delayed by two edges, and window of the last DB synchronised samples.
    logic [7:0] m_d1, m_d2, m_out;
    logic       m_chg;
    logic [7:0] win[$];

    key_debounce #(.WIDTH(8), .CNT_W(16), .DB_CYCLES(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw),
        .key_out (key_out)
`ifdef KEY_DEBOUNCE_CHG_EN
        ,
        .key_chg (key_chg)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A bit flips once every sample in a full window disagrees with its current value.
    task automatic model_edge();
        logic [7:0] flip;
        logic [7:0] prev;
        prev = m_out;
        if (reset) begin
            m_d1 = 8'hFF;
            m_d2 = 8'hFF;
            m_out = 8'hFF;
            m_chg = 1'b0;
            win.delete();
        end else begin
            win.push_back(m_d2);
            if (win.size() > DB) void'(win.pop_front());
            flip = 8'hFF;
            foreach (win[j]) flip &= (win[j] ^ m_out);
            if (win.size() == DB) m_out = m_out ^ flip;
            m_chg = (m_out != prev);
            m_d2 = m_d1;
            m_d1 = key_raw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_out", key_out, m_out);
`ifdef KEY_DEBOUNCE_CHG_EN
        check("model_chg", {7'b0, key_chg}, {7'b0, m_chg});
`endif
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_chg(input string tag, input logic exp);
`ifdef KEY_DEBOUNCE_CHG_EN
        check(tag, {7'b0, key_chg}, {7'b0, exp});
`endif
    endtask

    initial begin
        int hold;
        reset   = 1'b1;
        key_raw = 8'hFF;
        m_d1 = 8'hFF; m_d2 = 8'hFF; m_out = 8'hFF; m_chg = 1'b0;

        // Reset then idle
        ticks(2);
        check("reset_out", key_out, 8'hFF);
        check_chg("reset_chg", 1'b0);
        reset = 1'b0;
        ticks(10);
        check("idle_out", key_out, 8'hFF);

        // Single press on bit 0: visible on the 6th edge counting the first sample
        key_raw = 8'hFE;
        ticks(5);
        check("press_lat_early", key_out, 8'hFF);
        tick();
        check("press_lat", key_out, 8'hFE);
        check_chg("press_chg", 1'b1);
        tick();
        check_chg("press_chg_end", 1'b0);
        key_raw = 8'hFF;
        ticks(8);
        check("release", key_out, 8'hFF);

        // Short glitch on bit 3 is rejected
        key_raw = 8'hF7;
        ticks(3);
        key_raw = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("glitch_hold", key_out, 8'hFF);
        end

        // Bounce on bit 5, then stable low
        for (int b = 0; b < 4; b++) begin
            key_raw = (b % 2 == 0) ? 8'hDF : 8'hFF;
            ticks(2);
            check("bounce_hold", key_out, 8'hFF);
        end
        key_raw = 8'hDF;
        ticks(5);
        check("bounce_early", key_out, 8'hFF);
        tick();
        check("bounce_accept", key_out, 8'hDF);
        key_raw = 8'hFF;
        ticks(8);

        // All bits at once
        key_raw = 8'h00;
        ticks(5);
        check("all_early", key_out, 8'hFF);
        tick();
        check("all_flip", key_out, 8'h00);
        check_chg("all_chg", 1'b1);
        tick();
        check_chg("all_chg_end", 1'b0);
        key_raw = 8'hFF;
        ticks(8);
        check("all_release", key_out, 8'hFF);

        // Reset mid-count, then after acceptance, with bit 0 held pressed
        key_raw = 8'hFE;
        ticks(3);
        reset = 1'b1;
        ticks(2);
        check("rst_mid", key_out, 8'hFF);
        reset = 1'b0;
        ticks(5);
        check("rst_mid_early", key_out, 8'hFF);
        tick();
        check("rst_mid_accept", key_out, 8'hFE);
        ticks(2);
        reset = 1'b1;
        ticks(2);
        check("rst_after", key_out, 8'hFF);
        check_chg("rst_after_chg", 1'b0);
        reset = 1'b0;
        tick();
        check("rst_release", key_out, 8'hFF);
        ticks(4);
        check("rst_reaccept_early", key_out, 8'hFF);
        tick();
        check("rst_reaccept", key_out, 8'hFE);

        // Random key activity with occasional resets
        for (int r = 0; r < 120; r++) begin
            if ($urandom_range(0, 3) == 0) key_raw = 8'($urandom);
            else key_raw = key_raw ^ (8'h1 << $urandom_range(0, 7));
            hold = int'($urandom_range(1, 8));
            reset = ($urandom_range(0, 40) == 0);
            for (int k = 0; k < hold; k++) begin
                tick();
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
